// File: rtl/wb_regfile_if.sv
// Decode-stage bundle for wb_regfile: writeback bundle, operand reads,
// issue/scoreboard handshake and sticky error flags.
interface wb_regfile_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH+ADDR_WIDTH:0] WB;
  logic [ADDR_WIDTH-1:0]          RsrcAddr1;
  logic [ADDR_WIDTH-1:0]          RsrcAddr2;
  logic [DATA_WIDTH-1:0]          Rdata1;
  logic [DATA_WIDTH-1:0]          Rdata2;
  logic                           IssueValid;
  logic                           IssueWB;
  logic [ADDR_WIDTH-1:0]          IssueRdst;
  logic                           Busy1;
  logic                           Busy2;
  logic                           IssueFull;
  logic                           Overflow;
  logic                           Underflow;

  modport master (
    output WB, RsrcAddr1, RsrcAddr2, IssueValid, IssueWB, IssueRdst,
    input  Rdata1, Rdata2, Busy1, Busy2, IssueFull, Overflow, Underflow
  );

  modport slave (
    input  WB, RsrcAddr1, RsrcAddr2, IssueValid, IssueWB, IssueRdst,
    output Rdata1, Rdata2, Busy1, Busy2, IssueFull, Overflow, Underflow
  );
endinterface

// File: rtl/wb_regfile.sv
// Eight-entry register file with per-register pending-write scoreboard.
// Define WB_REGFILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module wb_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int PEND_WIDTH = 2
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [PEND_WIDTH-1:0] r_pend [NUM_REGS];
  logic                  r_overflow;
  logic                  r_underflow;

  logic [PEND_WIDTH-1:0] w_pend_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]   w_inc_hit;
  logic [NUM_REGS-1:0]   w_dec_hit;

  logic                  w_wb_en;
  logic [ADDR_WIDTH-1:0] w_wb_addr;
  logic [DATA_WIDTH-1:0] w_wb_data;
  logic                  w_issue_req;
  logic                  w_issue_full;
  logic                  w_inc;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic [PEND_WIDTH-1:0] w_pend_rd1;
  logic [PEND_WIDTH-1:0] w_pend_rd2;
  logic                  w_byp1;
  logic                  w_byp2;

  assign w_wb_en   = bus.WB[0];
  assign w_wb_addr = bus.WB[ADDR_WIDTH:1];
  assign w_wb_data = bus.WB[DATA_WIDTH+ADDR_WIDTH:ADDR_WIDTH+1];

  assign w_issue_req  = bus.IssueValid & bus.IssueWB;
  assign w_issue_full = (r_pend[bus.IssueRdst] == PEND_MAX);
  assign w_inc        = w_issue_req & ~w_issue_full;
  assign w_ovf_set    = w_issue_req & w_issue_full;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_hit
    assign w_inc_hit[g] = w_inc   & (bus.IssueRdst == ADDR_WIDTH'(g));
    assign w_dec_hit[g] = w_wb_en & (w_wb_addr     == ADDR_WIDTH'(g));
  end

  // A writeback that coincides with an issue to the same register cancels out,
  // so it is never an underflow even when the counter is zero.
  assign w_udf_set = w_wb_en & ~w_inc_hit[w_wb_addr] & (r_pend[w_wb_addr] == '0);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pend_nxt[i] = r_pend[i];
      if (w_inc_hit[i] && !w_dec_hit[i]) begin
        w_pend_nxt[i] = r_pend[i] + PEND_ONE;
      end else if (!w_inc_hit[i] && w_dec_hit[i] && (r_pend[i] != '0)) begin
        w_pend_nxt[i] = r_pend[i] - PEND_ONE;
      end
    end
  end

  // NOTE: the register array is reset like ordinary flops because its reset
  // value is architecturally visible on the read ports; state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= '0;
      end
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wb_en) begin
        r_regs[w_wb_addr] <= w_wb_data;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        r_pend[i] <= w_pend_nxt[i];
      end
      r_overflow  <= r_overflow  | w_ovf_set;
      r_underflow <= r_underflow | w_udf_set;
    end
  end

  assign w_pend_rd1 = r_pend[bus.RsrcAddr1];
  assign w_pend_rd2 = r_pend[bus.RsrcAddr2];

`ifdef WB_REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so reads show the cleared state.
  assign w_byp1 = ~rst & w_wb_en & (w_wb_addr == bus.RsrcAddr1);
  assign w_byp2 = ~rst & w_wb_en & (w_wb_addr == bus.RsrcAddr2);

  assign bus.Rdata1 = w_byp1 ? w_wb_data : r_regs[bus.RsrcAddr1];
  assign bus.Rdata2 = w_byp2 ? w_wb_data : r_regs[bus.RsrcAddr2];
  assign bus.Busy1  = (w_pend_rd1 != '0) & ~(w_byp1 & (w_pend_rd1 == PEND_ONE));
  assign bus.Busy2  = (w_pend_rd2 != '0) & ~(w_byp2 & (w_pend_rd2 == PEND_ONE));
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;

  assign bus.Rdata1 = r_regs[bus.RsrcAddr1];
  assign bus.Rdata2 = r_regs[bus.RsrcAddr2];
  assign bus.Busy1  = (w_pend_rd1 != '0) & ~w_byp1;
  assign bus.Busy2  = (w_pend_rd2 != '0) & ~w_byp2;
`endif

  assign bus.IssueFull = w_issue_full;
  assign bus.Overflow  = r_overflow;
  assign bus.Underflow = r_underflow;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_wb_regfile;
`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] m_reg  [8];
  int          m_pend [8];
  bit          m_ovf;
  bit          m_udf;

  wb_regfile_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  wb_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .PEND_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = 16'h0000;
      m_pend[i] = 0;
    end
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  function automatic logic [15:0] exp_rdata(input logic [2:0] a);
    if (BYP && !rst && bus.WB[0] && (bus.WB[3:1] == a)) return bus.WB[19:4];
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    if (m_pend[a] == 0) return 1'b0;
    if (BYP && !rst && bus.WB[0] && (bus.WB[3:1] == a) && (m_pend[a] == 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic       full;
    logic       inc;
    logic       dec;
    logic [2:0] wa;
    logic [2:0] rd;
    rd   = bus.IssueRdst;
    wa   = bus.WB[3:1];
    full = (m_pend[rd] == 3);
    inc  = bus.IssueValid && bus.IssueWB && !full;
    dec  = bus.WB[0];
    if (bus.IssueValid && bus.IssueWB && full) m_ovf = 1'b1;
    if (dec) m_reg[wa] = bus.WB[19:4];
    if (!(inc && dec && (rd == wa))) begin
      if (inc) m_pend[rd] = m_pend[rd] + 1;
      if (dec) begin
        if (m_pend[wa] > 0) m_pend[wa] = m_pend[wa] - 1;
        else                m_udf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("rdata1",    bus.Rdata1,    exp_rdata(bus.RsrcAddr1));
    check("rdata2",    bus.Rdata2,    exp_rdata(bus.RsrcAddr2));
    check("busy1",     bus.Busy1,     exp_busy(bus.RsrcAddr1));
    check("busy2",     bus.Busy2,     exp_busy(bus.RsrcAddr2));
    check("issuefull", bus.IssueFull, (m_pend[bus.IssueRdst] == 3));
    check("overflow",  bus.Overflow,  m_ovf);
    check("underflow", bus.Underflow, m_udf);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.WB         = '0;
    bus.IssueValid = 1'b0;
    bus.IssueWB    = 1'b0;
    bus.IssueRdst  = '0;
  endtask

  task automatic issue(input logic [2:0] rd);
    bus.IssueValid = 1'b1;
    bus.IssueWB    = 1'b1;
    bus.IssueRdst  = rd;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.RsrcAddr1 = '0;
    bus.RsrcAddr2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Basic write then read of R5
    bus.WB = {16'hBEEF, 3'd5, 1'b1};
    bus.RsrcAddr1 = 3'd5;
    #1 check("wr_same_cycle", bus.Rdata1, BYP ? 16'hBEEF : 16'h0000);
    step();
    bus.WB = '0;
    #1 check("wr_next_cycle", bus.Rdata1, 16'hBEEF);
    step();

    // Two issues to R3, then two writebacks
    bus.RsrcAddr1 = 3'd3;
    issue(3'd3);
    #1 check("sb_issue0_busy", bus.Busy1, 1'b0);
    step();
    #1 check("sb_issue1_busy", bus.Busy1, 1'b1);
    step();
    idle();
    bus.WB = {16'h1111, 3'd3, 1'b1};
    #1 check("sb_wb1_busy", bus.Busy1, 1'b1);
    step();
    bus.WB = {16'h2222, 3'd3, 1'b1};
    #1 check("sb_wb2_busy", bus.Busy1, BYP ? 1'b0 : 1'b1);
    step();
    bus.WB = '0;
    #1 check("sb_after_busy", bus.Busy1, 1'b0);
    check("sb_after_data", bus.Rdata1, 16'h2222);
    step();

    // Simultaneous issue and writeback on R2 with one write pending
    bus.RsrcAddr2 = 3'd2;
    issue(3'd2);
    step();
    bus.WB = {16'hABCD, 3'd2, 1'b1};
    step();
    idle();
    #1 check("sim_busy", bus.Busy2, 1'b1);
    check("sim_data", bus.Rdata2, 16'hABCD);
    step();

    // Saturate R7 and overflow it
    issue(3'd7);
    repeat (3) step();
    #1 check("sat_full", bus.IssueFull, 1'b1);
    check("sat_no_ovf_yet", bus.Overflow, 1'b0);
    step();
    bus.IssueValid = 1'b0;
    #1 check("sat_ovf", bus.Overflow, 1'b1);
    check("sat_still_full", bus.IssueFull, 1'b1);
    repeat (3) step();

    // Underflow on R1
    bus.WB = {16'h1234, 3'd1, 1'b1};
    bus.RsrcAddr1 = 3'd1;
    step();
    bus.WB = '0;
    #1 check("udf_flag", bus.Underflow, 1'b1);
    check("udf_data", bus.Rdata1, 16'h1234);
    check("udf_busy", bus.Busy1, 1'b0);
    step();

    // Asynchronous reset mid-cycle with a writeback and issue in flight
    bus.WB = {16'h5A5A, 3'd4, 1'b1};
    issue(3'd4);
    bus.RsrcAddr1 = 3'd4;
    bus.RsrcAddr2 = 3'd7;
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    check("arst_ovf", bus.Overflow, 1'b0);
    check("arst_busy2", bus.Busy2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1 check("arst_discard", bus.Rdata1, 16'h0000);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.WB         = {16'($urandom), 3'($urandom), 1'($urandom)};
      bus.IssueValid = 1'($urandom);
      bus.IssueWB    = ($urandom_range(0, 3) != 0);
      bus.IssueRdst  = 3'($urandom);
      bus.RsrcAddr1  = 3'($urandom);
      bus.RsrcAddr2  = 3'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Eight-entry, 16-bit register file that terminates the 20-bit writeback bundle produced by the writeback stage and serves the decode stage's two source-operand reads. It also keeps a per-register pending-write scoreboard: decode marks a destination when it issues a writing instruction, and writeback clears the mark when the value lands. This lets decode detect read-after-write hazards and stall. The block sits in the decode stage and closes the WB→ID loop.

## Interface
- DATA_WIDTH, 16, register and writeback value width
- ADDR_WIDTH, 3, register index width (2^ADDR_WIDTH registers, R0..R7)
- PEND_WIDTH, 2, width of each per-register pending-write counter (max 3 in flight)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- WB  in  20  writeback bundle: WB[19:4] = write value, WB[3:1] = Rdst, WB[0] = write enable
- RsrcAddr1  in  3  read port 1 index
- RsrcAddr2  in  3  read port 2 index
- Rdata1  out  16  read port 1 data (combinational)
- Rdata2  out  16  read port 2 data (combinational)
- IssueValid  in  1  decode issues an instruction this cycle
- IssueWB  in  1  issued instruction writes a register
- IssueRdst  in  3  destination of issued instruction
- Busy1  out  1  register at RsrcAddr1 has an outstanding write
- Busy2  out  1  register at RsrcAddr2 has an outstanding write
- IssueFull  out  1  counter of IssueRdst is at maximum (2^PEND_WIDTH−1)
- Overflow  out  1  sticky: issue attempted against a saturated counter
- Underflow  out  1  sticky: writeback to a register whose counter is 0

## Operation
- Write: when WB[0]=1, Reg[WB[3:1]] ← WB[19:4] on the rising edge. All eight registers are general-purpose; R0 is not hardwired.
- Read: Rdata1 = Reg[RsrcAddr1] and Rdata2 = Reg[RsrcAddr2], as asynchronous reads.
- Scoreboard: each register has a PEND_WIDTH-bit counter Pend[r].
  - inc = IssueValid & IssueWB & ~IssueFull targeting IssueRdst.
  - dec = WB[0] targeting WB[3:1].
- Per register, per cycle:
  - inc only: +1.
  - dec only: −1 if Pend > 0; if Pend = 0, hold and set Underflow. The register write still occurs.
  - inc and dec on the same register: no change.
- Saturation: IssueValid & IssueWB with Pend[IssueRdst] at max means the increment is dropped and Overflow is set. Decode is required to stall on IssueFull, so this is an error condition only.
- Busy generation: Busyn = (Pend[RsrcAddrn] ≠ 0), except as modified by the bypass (see Configuration).
- Overflow and Underflow stay set until rst.
- Reset mid-operation: all registers, counters and flags clear immediately. An in-flight writeback in the reset cycle is discarded.

## Timing
- Reset values:
  - all Reg = 0x0000, all Pend = 0.
  - Rdata1/2 = 0x0000, Busy1/2 = 0, IssueFull = 0, Overflow = 0, Underflow = 0.
- Register write latency: one edge. Without bypass, the value is readable in the cycle after WB[0] is asserted.
- Scoreboard latency:
  - an issue in cycle N makes Busy visible from cycle N+1.
  - a writeback in cycle N clears Busy from cycle N+1 (or in cycle N with bypass).
- IssueFull is combinational from the registered Pend and IssueRdst.
- No handshake back-pressure on WB: the writeback stage never stalls, and every WB[0]=1 is accepted.

## Configuration
- WB_REGFILE_BYPASS_EN defined:
  - Write-through: if WB[0]=1 and WB[3:1] equals RsrcAddrn, then Rdatan = WB[19:4] in the same cycle.
  - Busyn is deasserted in that cycle when Pend[RsrcAddrn] = 1, since the last outstanding write is completing.
- Not defined:
  - Reads return the pre-write register value during the write cycle.
  - Busy is based only on registered Pend, so decode stalls one extra cycle per RAW hazard.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all Rdata = 0x0000, all flags 0, no Busy, with or without a pending WB.
- Basic write/read: WB = {0xBEEF, R5, 1}, RsrcAddr1 = 5.
  - Without bypass: Rdata1 = 0x0000 in the same cycle and 0xBEEF on the next.
  - With bypass: 0xBEEF in the same cycle.
- Scoreboard:
  - issue to R3 twice (cycles 0, 1) → Busy1 (RsrcAddr1 = 3) high from cycle 1.
  - first WB to R3 → still busy.
  - second WB → Busy1 low the next cycle (same cycle with bypass).
- Simultaneous events: issue to R2 and WB to R2 in the same cycle with Pend[2] = 1 → Pend stays 1, Reg[2] updated, Busy stays high.
- Saturation: three issues to R7 → IssueFull = 1. A fourth issue → Pend unchanged at 3 and Overflow = 1, held until rst.
- Underflow: WB = {0x1234, R1, 1} with Pend[1] = 0 → Reg[1] = 0x1234, Pend[1] = 0, Underflow = 1.
